alu_issue: RTL and testbench
============================

# alu_issue

Execute-stage front end for the combinational ALU. Accepts decoded instruction fields and register operands over a valid/ready handshake, derives the 4-bit ALU Operation, drives registered SrcA/SrcB/Operation into the ALU, and captures ALUResult into a held result register with a branch-taken flag. It is the driving end of the ALU's SrcA/SrcB/Operation/ALUResult interface, sitting between decode and writeback.

## Interface
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU Operation width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has an operation
- in_ready  out  1  block can accept this cycle
- ALUOp  in  2  main-decoder class: 00 mem-address, 01 branch, 10 arith/logic, 11 reserved
- Funct3  in  3  instruction funct3
- Funct7  in  7  instruction funct7
- ALUSrc  in  1  1 = SrcB from Imm (I-type), 0 = from rs2_data
- rs1_data, rs2_data, Imm  in  DATA_WIDTH each  operands
- SrcA, SrcB  out  DATA_WIDTH  registered ALU operands
- Operation  out  OPCODE_LENGTH  registered ALU operation code
- ALUResult  in  DATA_WIDTH  combinational result from the ALU
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  downstream consumes result
- result  out  DATA_WIDTH  captured ALUResult
- branch_taken  out  1  captured Operation==BEQ and ALUResult[0]
- illegal  out  1  captured operation failed decode (see Configuration)

## Operation
- Codes: AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, BEQ 1000.
- Decode: ALUOp 00 -> ADD. ALUOp 01: Funct3 000 -> BEQ, else illegal. ALUOp 10: Funct3 000 -> SUB if ALUSrc=0 and Funct7=0100000, else ADD; 111 AND; 110 OR; 100 XOR; any other Funct3 or Funct7 not in {0000000, 0100000} on R-type -> illegal. ALUOp 11 -> illegal.
- FSM states IDLE, ISSUE, DONE.
  - IDLE: in_ready=1. On in_valid: latch SrcA=rs1_data, SrcB=(ALUSrc?Imm:rs2_data), Operation, illegal flag; -> ISSUE.
  - ISSUE: in_ready=0. Capture result=ALUResult (0 if illegal), branch_taken, illegal; -> DONE.
  - DONE: out_valid=1, result held stable. in_ready=out_ready. On out_ready & in_valid: latch new op, -> ISSUE. On out_ready & !in_valid: -> IDLE. Else stay.
- SrcA/SrcB/Operation stay unchanged until the next accept; no width extension, operands pass as DATA_WIDTH.

## Timing
- Reset (synchronous, dominant over all other inputs): state IDLE; SrcA, SrcB, Operation, result, branch_taken, illegal, out_valid = 0; in_ready = 0 while reset is high, 1 in first cycle after.
- Accept at edge E0 -> ALU inputs valid from E0 -> result captured at E1 -> out_valid=1 from E1. Latency 2 edges; max throughput 1 op / 2 cycles.
- Backpressure: out_valid held with result/branch_taken/illegal stable until out_ready sampled high.
- Simultaneous consume+accept in DONE: out_valid stays 1 through ISSUE? No: out_valid drops for the ISSUE cycle, rises again at next edge.
- Reset mid-ISSUE or mid-DONE: transaction discarded, no out_valid pulse.

## Configuration
- ALU_ISSUE_TRAP_EN defined: illegal decodes issue Operation 0000 with result forced 0, illegal=1 reported with out_valid.
- Undefined: illegal decodes issue as ADD (0010), result is the ALU sum, illegal output tied 0.

## Structure
- Package alu_pkg: alu_op_t enum (six codes above), ALUOp class constants, FUNCT7_SUB/FUNCT7_BASE constants, issue_state_t enum.
- Sub-module alu_op_decode: combinational ALUOp/Funct3/Funct7/ALUSrc -> {Operation, illegal}. ALU instantiated by parent, not inside this block.

## Test plan
- Reset 3 cycles with in_valid=1 -> all outputs 0, in_ready=0; first cycle after reset in_ready=1.
- ALUOp=10, Funct3=000, Funct7=0100000, ALUSrc=0, rs1=10, rs2=3 -> Operation=0011 one edge after accept, result=7, out_valid two edges after accept.
- ALUOp=10, Funct3=000, Funct7=0100000, ALUSrc=1, Imm=0xFFFFFFFF, rs1=5 -> Operation=0010, result=4 (ADDI, no SUB).
- ALUOp=01, Funct3=000, rs1=rs2=0x1234 -> Operation=1000, result=1, branch_taken=1; rs2=0x1235 -> branch_taken=0.
- out_ready=0 for 5 cycles after out_valid with in_valid=1 -> result stable, in_ready=0; raise out_ready -> consume and accept same edge, next result two edges later.
- ALUOp=11 -> with ALU_ISSUE_TRAP_EN: illegal=1, result=0; without: Operation=0010, illegal=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: operation codes, decoder class constants, FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_XOR = 4'b0100,
        OP_BEQ = 4'b1000
    } alu_op_t;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [1:0] ALUOP_RSVD   = 2'b11;

    localparam logic [6:0] FUNCT7_SUB  = 7'b0100000;
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_issue_if.sv
// Decode-side handshake, ALU operand/result bus and writeback handshake of the issue stage.
interface alu_issue_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               ALUOp;
    logic [2:0]               Funct3;
    logic [6:0]               Funct7;
    logic                     ALUSrc;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    Imm;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    ALUResult;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    result;
    logic                     branch_taken;
    logic                     illegal;

    modport slave (
        input  in_valid, ALUOp, Funct3, Funct7, ALUSrc, rs1_data, rs2_data, Imm,
        input  ALUResult, out_ready,
        output in_ready, SrcA, SrcB, Operation, out_valid, result, branch_taken, illegal
    );

    modport master (
        output in_valid, ALUOp, Funct3, Funct7, ALUSrc, rs1_data, rs2_data, Imm,
        output ALUResult, out_ready,
        input  in_ready, SrcA, SrcB, Operation, out_valid, result, branch_taken, illegal
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/Funct3/Funct7/ALUSrc -> ALU operation plus raw illegal flag.
// Illegal encodings report OP_ADD here; the parent decides how they are actually issued.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    input  logic       i_alu_src,
    output alu_op_t    o_op,
    output logic       o_illegal
);

    always_comb begin
        o_op      = OP_ADD;
        o_illegal = 1'b0;
        case (i_alu_op)
            ALUOP_MEM: o_op = OP_ADD;
            ALUOP_BRANCH: begin
                if (i_funct3 == 3'b000) o_op = OP_BEQ;
                else                    o_illegal = 1'b1;
            end
            ALUOP_ARITH: begin
                case (i_funct3)
                    3'b000:  o_op = (!i_alu_src && i_funct7 == FUNCT7_SUB) ? OP_SUB : OP_ADD;
                    3'b111:  o_op = OP_AND;
                    3'b110:  o_op = OP_OR;
                    3'b100:  o_op = OP_XOR;
                    default: o_illegal = 1'b1;
                endcase
                // Funct7 only qualifies R-type; immediates carry arbitrary upper bits
                if (!i_alu_src && i_funct7 != FUNCT7_SUB && i_funct7 != FUNCT7_BASE)
                    o_illegal = 1'b1;
                if (o_illegal) o_op = OP_ADD;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: accept decoded op, drive registered SrcA/SrcB/Operation, capture ALUResult (2 edges).
// ALU_ISSUE_TRAP_EN: illegal decodes issue 0000, result forced 0, illegal reported; otherwise issue as ADD.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    alu_issue_if.slave  bus
);

    issue_state_t          r_state;
    issue_state_t          w_next;
    logic                  w_in_ready;
    logic                  w_accept;

    alu_op_t               w_dec_op;
    logic                  w_dec_illegal;
    alu_op_t               w_op;
    logic                  w_illegal;

    logic [DATA_WIDTH-1:0] r_src_a;
    logic [DATA_WIDTH-1:0] r_src_b;
    alu_op_t               r_op;
    logic                  r_op_illegal;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_branch_taken;
    logic                  r_illegal;

    alu_op_decode u_decode (
        .i_alu_op  (bus.ALUOp),
        .i_funct3  (bus.Funct3),
        .i_funct7  (bus.Funct7),
        .i_alu_src (bus.ALUSrc),
        .o_op      (w_dec_op),
        .o_illegal (w_dec_illegal)
    );

`ifdef ALU_ISSUE_TRAP_EN
    assign w_op      = w_dec_illegal ? OP_AND : w_dec_op;
    assign w_illegal = w_dec_illegal;
`else
    assign w_op      = w_dec_illegal ? OP_ADD : w_dec_op;
    assign w_illegal = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = S_ISSUE;
            end
            S_ISSUE: w_next = S_DONE;
            S_DONE: begin
                // a consume frees the result register for a back-to-back accept
                w_in_ready = bus.out_ready;
                if (bus.out_ready) w_next = bus.in_valid ? S_ISSUE : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (reset) w_in_ready = 1'b0;
    end

    assign w_accept = w_in_ready && bus.in_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_src_a        <= '0;
            r_src_b        <= '0;
            r_op           <= OP_AND;
            r_op_illegal   <= 1'b0;
            r_result       <= '0;
            r_branch_taken <= 1'b0;
            r_illegal      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_src_a      <= bus.rs1_data;
                r_src_b      <= bus.ALUSrc ? bus.Imm : bus.rs2_data;
                r_op         <= w_op;
                r_op_illegal <= w_illegal;
            end
            if (r_state == S_ISSUE) begin
                r_result       <= r_op_illegal ? '0 : bus.ALUResult;
                r_branch_taken <= (r_op == OP_BEQ) && bus.ALUResult[0];
                r_illegal      <= r_op_illegal;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.SrcA         = r_src_a;
    assign bus.SrcB         = r_src_b;
    assign bus.Operation    = OPCODE_LENGTH'(r_op);
    assign bus.out_valid    = (r_state == S_DONE);
    assign bus.result       = r_result;
    assign bus.branch_taken = r_branch_taken;
    assign bus.illegal      = r_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Random and directed bench for alu_issue: queue scoreboard fed at accept, drained by a negedge monitor.
module tb_alu_issue;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

    alu_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural ALU standing in for the real combinational ALU.
    always_comb begin
        case (bus.Operation)
            4'b0000: bus.ALUResult = bus.SrcA & bus.SrcB;
            4'b0001: bus.ALUResult = bus.SrcA | bus.SrcB;
            4'b0010: bus.ALUResult = bus.SrcA + bus.SrcB;
            4'b0011: bus.ALUResult = bus.SrcA - bus.SrcB;
            4'b0100: bus.ALUResult = bus.SrcA ^ bus.SrcB;
            4'b1000: bus.ALUResult = {31'd0, bus.SrcA == bus.SrcB};
            default: bus.ALUResult = 32'd0;
        endcase
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        bt;
        logic        ill;
        int          cyc;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    int   hold     = 0;
    bit   rnd_rdy  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] aluop, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic src,
                                   input logic [31:0] rs1, input logic [31:0] rs2,
                                   input logic [31:0] imm);
        exp_t e;
        logic legal;
        e.a   = rs1;
        e.b   = src ? imm : rs2;
        e.bt  = 1'b0;
        e.ill = 1'b0;
        e.cyc = 0;
        legal = (aluop == 2'd0) || (aluop == 2'd1 && f3 == 3'd0) ||
                (aluop == 2'd2 && (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd4) &&
                 (src || f7 == 7'h00 || f7 == 7'h20));
        if (!legal) begin
`ifdef ALU_ISSUE_TRAP_EN
            e.op = 4'd0; e.res = 32'd0; e.ill = 1'b1;
`else
            e.op = 4'd2; e.res = e.a + e.b;
`endif
        end else if (aluop == 2'd0) begin
            e.op = 4'd2; e.res = e.a + e.b;
        end else if (aluop == 2'd1) begin
            e.op = 4'd8; e.bt = (e.a == e.b); e.res = {31'd0, e.bt};
        end else if (f3 == 3'd0 && !src && f7 == 7'h20) begin
            e.op = 4'd3; e.res = e.a - e.b;
        end else if (f3 == 3'd0) begin
            e.op = 4'd2; e.res = e.a + e.b;
        end else if (f3 == 3'd7) begin
            e.op = 4'd0; e.res = e.a & e.b;
        end else if (f3 == 3'd6) begin
            e.op = 4'd1; e.res = e.a | e.b;
        end else begin
            e.op = 4'd4; e.res = e.a ^ e.b;
        end
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic rst_at_edge = 1'b1;
    always @(posedge clk) rst_at_edge <= reset;

    int   cyc = 0;
    bit   prev_rst = 1;
    bit   prev_vld = 0;
    bit   prev_cons = 0;
    bit   pend = 0;
    exp_t pend_e;
    exp_t cur;
    logic [31:0] h_res;
    logic        h_bt, h_ill;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            q.delete();
            pend      = 0;
            prev_rst  = 1;
            prev_vld  = 0;
            prev_cons = 0;
            chk("rst_in_ready", bus.in_ready, 0);
            if (rst_at_edge) begin
                chk("rst_out_valid", bus.out_valid, 0);
                chk("rst_srca", bus.SrcA, 0);
                chk("rst_srcb", bus.SrcB, 0);
                chk("rst_op", bus.Operation, 0);
                chk("rst_result", bus.result, 0);
                chk("rst_bt", bus.branch_taken, 0);
                chk("rst_illegal", bus.illegal, 0);
            end
        end else begin
            if (prev_rst) chk("in_ready_after_reset", bus.in_ready, 1);
            prev_rst = 0;
            if (pend) begin
                chk("issue_op", bus.Operation, pend_e.op);
                chk("issue_srca", bus.SrcA, pend_e.a);
                chk("issue_srcb", bus.SrcB, pend_e.b);
                pend = 0;
            end
            if (bus.out_valid) begin
                chk("in_ready_in_done", bus.in_ready, bus.out_ready);
                if (!prev_vld || prev_cons) begin
                    if (q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending op at %0t", $time);
                    end else begin
                        cur = q[0];
                        chk("latency", cyc - cur.cyc, 2);
                        chk("result", bus.result, cur.res);
                        chk("branch_taken", bus.branch_taken, cur.bt);
                        chk("illegal", bus.illegal, cur.ill);
                    end
                    h_res = bus.result; h_bt = bus.branch_taken; h_ill = bus.illegal;
                end else begin
                    chk("hold_result", bus.result, h_res);
                    chk("hold_bt", bus.branch_taken, h_bt);
                    chk("hold_illegal", bus.illegal, h_ill);
                end
            end
            prev_cons = bus.out_valid && bus.out_ready;
            if (prev_cons && q.size() > 0) void'(q.pop_front());
            prev_vld = bus.out_valid;
            if (bus.in_valid && bus.in_ready) begin
                pend_e = model(bus.ALUOp, bus.Funct3, bus.Funct7, bus.ALUSrc,
                               bus.rs1_data, bus.rs2_data, bus.Imm);
                pend_e.cyc = cyc;
                q.push_back(pend_e);
                pend = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_ready();
        if (hold > 0) begin
            bus.out_ready = 1'b0;
            hold--;
        end else begin
            bus.out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #2;
            drive_ready();
        end
    endtask

    task automatic send(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                        input logic src, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm);
        bit acc = 0;
        bus.ALUOp = aluop; bus.Funct3 = f3; bus.Funct7 = f7; bus.ALUSrc = src;
        bus.rs1_data = rs1; bus.rs2_data = rs2; bus.Imm = imm;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #2;
            drive_ready();
        end
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles expected an accept");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_random();
        logic [1:0]  aluop = 2'($urandom_range(0, 3));
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1 = $urandom;
        logic [31:0] rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
        int sel = $urandom_range(0, 5);
        case (sel)
            0: f3 = 3'd0; 1: f3 = 3'd7; 2: f3 = 3'd6; 3: f3 = 3'd4;
            default: f3 = 3'($urandom_range(0, 7));
        endcase
        case ($urandom_range(0, 3))
            0: f7 = 7'h00; 1: f7 = 7'h20; 2: f7 = 7'h20;
            default: f7 = 7'($urandom_range(0, 127));
        endcase
        send(aluop, f3, f7, 1'($urandom_range(0, 1)), rs1, rs2, $urandom);
    endtask

    initial begin
        reset = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.ALUOp = 2'b10; bus.Funct3 = 3'd0; bus.Funct7 = 7'h00; bus.ALUSrc = 1'b0;
        bus.rs1_data = 32'hDEAD; bus.rs2_data = 32'hBEEF; bus.Imm = 32'h1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        send(2'b10, 3'b000, 7'b0100000, 1'b0, 32'd10, 32'd3, 32'd0);
        send(2'b10, 3'b000, 7'b0100000, 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF);
        send(2'b01, 3'b000, 7'd0, 1'b0, 32'h1234, 32'h1234, 32'd0);
        send(2'b01, 3'b000, 7'd0, 1'b0, 32'h1234, 32'h1235, 32'd0);
        send(2'b11, 3'b000, 7'd0, 1'b0, 32'd7, 32'd9, 32'd0);
        send(2'b10, 3'b111, 7'h05, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0);
        idle(4);

        hold = 7;
        send(2'b10, 3'b100, 7'd0, 1'b0, 32'hAAAA5555, 32'hFFFF0000, 32'd0);
        send(2'b10, 3'b110, 7'd0, 1'b0, 32'h00F0, 32'h0F00, 32'd0);
        idle(6);

        rnd_rdy = 1;
        repeat (300) begin
            send_random();
            idle($urandom_range(0, 2));
        end
        rnd_rdy = 0;
        idle(6);

        // reset while the op sits in ISSUE
        send(2'b00, 3'd0, 7'd0, 1'b0, 32'd1, 32'd2, 32'd0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_valid_after_issue_reset", bus.out_valid, 0);
        end
        @(posedge clk); #2;

        // reset while the result is held in DONE
        hold = 10;
        send(2'b00, 3'd0, 7'd0, 1'b0, 32'd3, 32'd4, 32'd0);
        idle(3);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        hold = 0;
        repeat (4) begin
            @(negedge clk);
            chk("no_valid_after_done_reset", bus.out_valid, 0);
        end
        @(posedge clk); #2;
        idle(2);

        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
